// File: rtl/sdram_ctrl_pkg.sv
// sdram_ctrl_pkg: command codes and refresh scheduler state encodings shared by the SDRAM controller
package sdram_ctrl_pkg;
  localparam logic [1:0] NOP           = 2'b00;
  localparam logic [1:0] PRECHARGE_ALL = 2'b01;
  localparam logic [1:0] REFRESH       = 2'b10;
  localparam logic [1:0] LOAD_MODE     = 2'b11;
  typedef enum logic [2:0] {PWRUP, PRE, IREF, LMR, RUN} sched_state_t;
endpackage

// File: rtl/sdram_interval_timer.sv
// sdram_interval_timer: free-running interval counter that pulses tick on limit-1 and wraps to 0
module sdram_interval_timer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  assign tick = cnt == limit - 1'b1;
  // count up, restarting from 0 on clear or at the terminal count
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt <= '0;
    else cnt <= (clear | tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sdram_refresh_scheduler.sv
// sdram_refresh_scheduler: SDRAM init sequence and auto-refresh backlog; REFRESH_BACKLOG_EN selects multi-entry backlog vs single flag
module sdram_refresh_scheduler
  import sdram_ctrl_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int PWRUP_CYCLES   = 20000,
  parameter int REF_INTERVAL   = 780,
  parameter int INIT_REFRESHES = 8,
  parameter int MAX_BACKLOG    = 8,
  parameter int URGENT_LEVEL   = 6,
  parameter int BL_W           = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            restart,
  output logic            cmd_valid,
  output logic [1:0]      cmd_code,
  input  logic            cmd_ready,
  output logic            init_done,
  output logic            urgent,
  output logic [BL_W-1:0] pending,
  output logic            overflow
);
`ifdef REFRESH_BACKLOG_EN
  localparam bit BACKLOG = 1'b1;
`else
  localparam bit BACKLOG = 1'b0;
`endif
  localparam int IC_W = $clog2(INIT_REFRESHES + 1);
  localparam logic [BL_W-1:0] CAP = BACKLOG ? BL_W'(MAX_BACKLOG) : BL_W'(1);
  sched_state_t state;
  logic [IC_W-1:0] init_cnt;
  logic tick, hs, run_tick, full, ovf_set;
  logic [BL_W-1:0] pend_nxt;
  sdram_interval_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clear(restart | (state != PWRUP && state != RUN)),
    .limit(state == PWRUP ? CNT_W'(PWRUP_CYCLES) : CNT_W'(REF_INTERVAL)),
    .tick (tick)
  );
  assign hs       = cmd_valid & cmd_ready;
  assign run_tick = tick & (state == RUN);
  assign full     = pending == CAP;
  assign ovf_set  = run_tick & ~hs & full;
  assign pend_nxt = (run_tick & ~hs & ~full) ? pending + 1'b1 : (hs & ~run_tick) ? pending - 1'b1 : pending;
  assign urgent   = BACKLOG ? pending >= BL_W'(URGENT_LEVEL) : pending[0];
  // init sequencing, RUN-time backlog and registered command request
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state     <= PWRUP;
      init_cnt  <= '0;
      pending   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= NOP;
      init_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (restart) begin
      state     <= PWRUP;
      init_cnt  <= '0;
      pending   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= NOP;
      init_done <= 1'b0;
    end else
      case (state)
        PWRUP: if (tick) begin
          state     <= PRE;
          cmd_valid <= 1'b1;
          cmd_code  <= PRECHARGE_ALL;
        end
        PRE: if (hs) begin
          state    <= IREF;
          init_cnt <= '0;
          cmd_code <= REFRESH;
        end
        IREF: if (hs) begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == IC_W'(INIT_REFRESHES - 1)) begin
            state    <= LMR;
            cmd_code <= LOAD_MODE;
          end
        end
        LMR: if (hs) begin
          state     <= RUN;
          cmd_valid <= 1'b0;
          cmd_code  <= NOP;
          init_done <= 1'b1;
        end
        RUN: begin
          pending   <= pend_nxt;
          cmd_valid <= pend_nxt != '0;
          cmd_code  <= pend_nxt != '0 ? REFRESH : NOP;
          if (ovf_set) overflow <= 1'b1;
        end
        default: state <= PWRUP;
      endcase
endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// tb_sdram_refresh_scheduler: scoreboard bench for init, periodic refresh, backlog, overflow and restart
module tb_sdram_refresh_scheduler;
  import sdram_ctrl_pkg::*;
  logic CLK = 1'b0, RST_N = 1'b0, restart = 1'b0, cmd_ready = 1'b1;
  logic cmd_valid, init_done, urgent, overflow;
  logic [1:0] cmd_code;
  logic [3:0] pending;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {int c; logic [1:0] code;} exp_t;
  exp_t q[$];
  sdram_refresh_scheduler #(
    .PWRUP_CYCLES(10), .REF_INTERVAL(20), .INIT_REFRESHES(2), .MAX_BACKLOG(4), .URGENT_LEVEL(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .restart(restart), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .init_done(init_done), .urgent(urgent), .pending(pending), .overflow(overflow)
  );
  always #5 CLK = ~CLK;
  // cycle index: value k right after the k-th rising edge following reset release
  always @(posedge CLK) if (RST_N) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask
  task automatic push(input int c, input logic [1:0] code);
    q.push_back('{c, code});
  endtask
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #2;
    end
  endtask
  // monitor: every handshake about to transfer at the next edge is matched against the scoreboard
  always @(negedge CLK)
    if (RST_N && cmd_valid && cmd_ready && !restart) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hs_extra at cyc %0d: got code %0d, expected no handshake", cyc, cmd_code);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hs_cyc", cyc, e.c);
        chk("hs_code", int'(cmd_code), int'(e.code));
      end
    end
  initial begin
    #100000;
    n_bad++;
    $display("FAIL timeout: got no finish, expected finish before 100000 ns");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_code", int'(cmd_code), int'(NOP));
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_urgent", int'(urgent), 0);
    chk("rst_overflow", int'(overflow), 0);
    push(10, PRECHARGE_ALL); push(11, REFRESH); push(12, REFRESH); push(13, LOAD_MODE);
    push(34, REFRESH); push(54, REFRESH);
    @(negedge CLK) RST_N = 1'b1;
    at(9);   chk("pwrup_valid", int'(cmd_valid), 0);
    at(14);  chk("init_done", int'(init_done), 1); chk("run_valid0", int'(cmd_valid), 0);
    at(34);  chk("tick1_pending", int'(pending), 1);
    at(55);  chk("hs_pending0", int'(pending), 0);
    cmd_ready = 1'b0;
`ifdef REFRESH_BACKLOG_EN
    at(74);  chk("bl_pend1", int'(pending), 1); chk("bl_urg1", int'(urgent), 0);
    at(94);  chk("bl_pend2", int'(pending), 2); chk("bl_urg2", int'(urgent), 0);
    at(114); chk("bl_pend3", int'(pending), 3); chk("bl_urg3", int'(urgent), 1);
    at(124); push(124, REFRESH); push(125, REFRESH); push(126, REFRESH);
    cmd_ready = 1'b1;
    at(127); chk("drain_pending", int'(pending), 0); chk("drain_valid", int'(cmd_valid), 0);
    cmd_ready = 1'b0;
    at(154); chk("pre_sim_pend", int'(pending), 2);
    at(173); push(173, REFRESH);
    cmd_ready = 1'b1;
    at(174); cmd_ready = 1'b0;
    chk("sim_tick_hs_pend", int'(pending), 2);
    at(214); chk("sat_pend", int'(pending), 4); chk("sat_ovf0", int'(overflow), 0); chk("sat_urg", int'(urgent), 1);
    at(234); chk("ovf_pend", int'(pending), 4); chk("ovf_set", int'(overflow), 1);
    at(235); restart = 1'b1;
    at(236); restart = 1'b0;
    chk("rs_pending", int'(pending), 0); chk("rs_valid", int'(cmd_valid), 0);
    chk("rs_ovf_kept", int'(overflow), 1); chk("rs_init_done", int'(init_done), 0);
    push(246, PRECHARGE_ALL);
    cmd_ready = 1'b1;
    at(247); restart = 1'b1;
    at(248); restart = 1'b0;
    chk("iref_rs_valid", int'(cmd_valid), 0);
    push(258, PRECHARGE_ALL); push(259, REFRESH); push(260, REFRESH); push(261, LOAD_MODE);
    at(262); chk("replay_init_done", int'(init_done), 1); chk("replay_ovf", int'(overflow), 1);
`else
    at(74);  chk("flag_pend", int'(pending), 1); chk("flag_urg", int'(urgent), 1); chk("flag_ovf0", int'(overflow), 0);
    at(94);  chk("flag_pend_sat", int'(pending), 1); chk("flag_ovf1", int'(overflow), 1);
    push(94, REFRESH);
    cmd_ready = 1'b1;
    at(95);  chk("flag_clear", int'(pending), 0);
    restart = 1'b1;
    at(96);  restart = 1'b0;
    chk("rs_ovf_kept", int'(overflow), 1);
    push(106, PRECHARGE_ALL); push(107, REFRESH); push(108, REFRESH);
    at(109); chk("lmr_code", int'(cmd_code), int'(LOAD_MODE));
    RST_N = 1'b0;
    #1;
    chk("arst_valid", int'(cmd_valid), 0); chk("arst_code", int'(cmd_code), int'(NOP));
    chk("arst_init_done", int'(init_done), 0); chk("arst_pending", int'(pending), 0);
    chk("arst_urgent", int'(urgent), 0); chk("arst_overflow", int'(overflow), 0);
`endif
    #20;
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
